thumb_streamer: RTL and testbench

Reads the 40x30 RGB thumbnail buffer of the camera downsampler in raster order and streams it out as one pixel per transfer over a valid/ready interface. It drives the buffer's read address, absorbs the buffer's one-cycle read latency, and tags frame/line boundaries. It sits between the downsampler's read port and the MARLANN input loader or display overlay, all in the downsampler's read-clock domain.

---
 rtl/thumb_pkg.sv | 32 +++
 rtl/thumb_skid_fifo.sv | 51 +++++
 rtl/thumb_streamer.sv | 166 ++++++++++++++++
 tb/tb_thumb_streamer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/thumb_pkg.sv
// Shared definitions for the thumbnail streamer: geometry, FSM states,
// per-pixel boundary tags and the optional grayscale conversion.
package thumb_pkg;

    localparam int THUMB_W      = 40;
    localparam int THUMB_H      = 30;
    localparam int THUMB_X_BITS = 6;
    localparam int THUMB_Y_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } thumb_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } thumb_tag_t;

    // One FIFO entry: tags above 24 bits of RGB.
    localparam int THUMB_ENTRY_BITS = 24 + $bits(thumb_tag_t);

    // Y = (R + 2G + B) >> 2, summed at 10 bits so it cannot overflow.
    function automatic logic [23:0] thumb_luma(input logic [23:0] rgb);
        logic [9:0] sum;
        sum = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
        return {3{sum[9:2]}};
    endfunction

endpackage

// File: rtl/thumb_skid_fifo.sv
// Two-entry FIFO holding pixels captured from the thumbnail buffer while
// the downstream sink stalls. Clear drops all entries in one cycle.
module thumb_skid_fifo #(
    parameter int DATA_BITS = 27
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head,
    output logic [1:0]           count
);

    logic [DATA_BITS-1:0] entry0;
    logic [DATA_BITS-1:0] entry1;
    logic                 wr_ptr;
    logic                 rd_ptr;

    // Storage, pointers and occupancy; clear leaves the stale data in place.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            entry0 <= '0;
            entry1 <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    entry1 <= push_data;
                end else begin
                    entry0 <= push_data;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = rd_ptr ? entry1 : entry0;

endmodule

// File: rtl/thumb_streamer.sv
// Scans the camera thumbnail buffer in raster order and streams one pixel
// per valid/ready transfer with sof/eol/eof tags.
// Optional feature macro: THUMB_STREAMER_GRAY_EN (replace RGB with {Y,Y,Y}).
module thumb_streamer
    import thumb_pkg::*;
#(
    parameter int WIDTH  = THUMB_W,
    parameter int HEIGHT = THUMB_H
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    abort,
    output logic [THUMB_X_BITS-1:0] read_x,
    output logic [THUMB_Y_BITS-1:0] read_y,
    input  logic [31:0]             read_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [23:0]             out_data,
    output logic                    out_sof,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic                    busy,
    output logic                    done
);

    localparam logic [THUMB_X_BITS-1:0] X_LAST = THUMB_X_BITS'(WIDTH - 1);
    localparam logic [THUMB_Y_BITS-1:0] Y_LAST = THUMB_Y_BITS'(HEIGHT - 1);

    thumb_state_t                state;
    thumb_state_t                state_next;
    logic                        issue;
    logic                        start_go;
    logic                        done_next;
    logic                        room;
    logic                        at_last;
    logic                        inflight;
    logic                        pop;
    thumb_tag_t                  issue_tag;
    thumb_tag_t                  tag_q;
    thumb_tag_t                  head_tag;
    logic [23:0]                 push_rgb;
    logic [23:0]                 head_rgb;
    logic [1:0]                  fifo_count;
    logic [THUMB_ENTRY_BITS-1:0] head_entry;
    logic [7:0]                  unused_alpha;

    assign unused_alpha = read_q[31:24];

    assign at_last        = (read_x == X_LAST) && (read_y == Y_LAST);
    assign issue_tag.sof  = (read_x == '0) && (read_y == '0);
    assign issue_tag.eol  = (read_x == X_LAST);
    assign issue_tag.eof  = at_last;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;

    // Reads already in the FIFO plus the one in flight, net of this cycle's
    // pop, must stay below the FIFO depth so a capture always has a slot.
    assign room = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    // A start coinciding with the done pulse belongs to the finished scan.
    assign start_go = start && !abort && (state == IDLE) && !done;

    // Next-state, read issue and done decode; abort overrides everything.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start_go) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                issue = room;
                if (room && at_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_tag.eof) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            issue      = 1'b0;
            done_next  = 1'b0;
        end
    end

    // FSM state register and registered done pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Raster address counters: cleared by start, advanced on each issue.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            read_x <= '0;
            read_y <= '0;
        end else if (start_go) begin
            read_x <= '0;
            read_y <= '0;
        end else if (issue) begin
            if (read_x == X_LAST) begin
                read_x <= '0;
                read_y <= read_y + 1'b1;
            end else begin
                read_x <= read_x + 1'b1;
            end
        end
    end

    // Track the single outstanding buffer read and the tags of its address.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inflight <= 1'b0;
            tag_q    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_q <= issue_tag;
            end
        end
    end

`ifdef THUMB_STREAMER_GRAY_EN
    assign push_rgb = thumb_luma(read_q[23:0]);
`else
    assign push_rgb = read_q[23:0];
`endif

    thumb_skid_fifo #(
        .DATA_BITS(THUMB_ENTRY_BITS)
    ) u_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (abort),
        .push     (inflight),
        .push_data({tag_q, push_rgb}),
        .pop      (pop),
        .head     (head_entry),
        .count    (fifo_count)
    );

    assign {head_tag, head_rgb} = head_entry;

    assign out_data = head_rgb;
    assign out_sof  = out_valid && head_tag.sof;
    assign out_eol  = out_valid && head_tag.eol;
    assign out_eof  = out_valid && head_tag.eof;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_thumb_streamer.sv
// Directed bench for thumb_streamer: full frames, stalls, abort, start
// filtering, mid-frame reset, a 1-column instance and (with
// THUMB_STREAMER_GRAY_EN) the grayscale conversion.
module tb_thumb_streamer;

    localparam int W = 40;
    localparam int H = 30;
    localparam int N = W * H;

    logic        clock;
    logic        resetn;
    logic        start, abort, out_ready;
    logic [5:0]  read_x;
    logic [4:0]  read_y;
    logic [31:0] read_q;
    logic        out_valid, out_sof, out_eol, out_eof, busy, done;
    logic [23:0] out_data;

    logic        start1, out_ready1;
    logic [5:0]  read_x1;
    logic [4:0]  read_y1;
    logic [31:0] read_q1;
    logic        out_valid1, out_sof1, out_eol1, out_eof1, busy1, done1;
    logic [23:0] out_data1;

    logic        gray_force;
    logic [31:0] gray_word;

    int n_checks = 0;
    int n_fail   = 0;
    int idx, done_cnt, done_at, frame_edges;
    int sof_cnt, eol_cnt, eof_cnt, issued, accepted, max_out;

    thumb_streamer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort),
        .read_x(read_x), .read_y(read_y), .read_q(read_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .done(done)
    );

    thumb_streamer #(.WIDTH(1), .HEIGHT(2)) dut_w1 (
        .clock(clock), .resetn(resetn), .start(start1), .abort(1'b0),
        .read_x(read_x1), .read_y(read_y1), .read_q(read_q1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_sof(out_sof1), .out_eol(out_eol1), .out_eof(out_eof1),
        .busy(busy1), .done(done1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] buf_word(input logic [5:0] x, input logic [4:0] y);
        logic [7:0] xr, yr;
        xr = {2'b00, x};
        yr = {3'b000, y};
        return {8'hEE, yr, xr, yr ^ xr};
    endfunction

    // Thumbnail buffer model with one clock of read latency.
    always @(posedge clock) begin
        read_q  <= gray_force ? gray_word : buf_word(read_x, read_y);
        read_q1 <= buf_word(read_x1, read_y1);
    end

    function automatic logic [23:0] exp_rgb(input int x, input int y);
        logic [7:0] r, g, b;
        logic [9:0] s;
        r = 8'(y);
        g = 8'(x);
        b = r ^ g;
        s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
`ifdef THUMB_STREAMER_GRAY_EN
        return {3{s[9:2]}};
`else
        if (s == 10'h3FF) return 24'h0;
        return {r, g, b};
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0; done_cnt = 0; done_at = -1; frame_edges = 0;
        sof_cnt = 0; eol_cnt = 0; eof_cnt = 0;
        issued = 0; accepted = 0; max_out = 0;
    endtask

    // Runs the sink side until stop_at pixels are accepted plus a tail,
    // checking every accepted pixel and output stability across stalls.
    task automatic stream(input int stop_at, input int tail_max, input bit rnd,
                          input int poke_at, input int limit);
        int          edges, tail, x, y;
        bit          stalled;
        logic [26:0] held, expv;
        logic [10:0] prev_addr;
        edges = 0; tail = 0; stalled = 0; held = '0;
        prev_addr = {read_y, read_x};
        while (edges < limit && tail < tail_max) begin
            if ({read_y, read_x} != prev_addr) issued++;
            prev_addr = {read_y, read_x};
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (stalled)
                check_eq("stall_hold", 32'({out_valid, out_sof, out_eol, out_eof, out_data}),
                         32'({1'b1, held}));
            if (done) begin
                done_cnt++;
                done_at = frame_edges;
                check_eq("busy_with_done", 32'(busy), 32'(0));
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (edges == poke_at);
            if (out_valid && out_ready) begin
                x = idx % W;
                y = idx / W;
                expv = {idx == 0, x == W - 1, idx == N - 1, exp_rgb(x, y)};
                check_eq($sformatf("pix%0d", idx),
                         32'({out_sof, out_eol, out_eof, out_data}), 32'(expv));
                sof_cnt += int'(out_sof);
                eol_cnt += int'(out_eol);
                eof_cnt += int'(out_eof);
                idx++;
                accepted++;
            end
            stalled = out_valid && !out_ready;
            held = {out_sof, out_eol, out_eof, out_data};
            if (idx >= stop_at) tail++;
            tick();
            edges++;
            frame_edges++;
        end
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d1, i1, quiet_done;
        resetn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start1 = 1'b0; out_ready1 = 1'b1; gray_force = 1'b0; gray_word = '0;
        #7;
        check_eq("reset_addr", 32'({read_y, read_x}), 32'(0));
        check_eq("reset_data", 32'(out_data), 32'(0));
        check_eq("reset_flags", 32'({out_valid, out_sof, out_eol, out_eof, busy, done}), 32'(0));
        #16 resetn = 1'b1;
        tick();

        // Full frame with the sink always ready.
        start_frame();
        check_eq("start_busy", 32'(busy), 32'(1));
        check_eq("start_addr", 32'({read_y, read_x}), 32'(0));
        check_eq("start_valid", 32'(out_valid), 32'(0));
        stream(N, 4, 1'b0, -1, N + 50);
        check_eq("f1_count", 32'(idx), 32'(N));
        check_eq("f1_sof", 32'(sof_cnt), 32'(1));
        check_eq("f1_eol", 32'(eol_cnt), 32'(H));
        check_eq("f1_eof", 32'(eof_cnt), 32'(1));
        check_eq("f1_done_cnt", 32'(done_cnt), 32'(1));
        check_eq("f1_done_at", 32'(done_at), 32'(N + 2));
        check_eq("f1_max_out", 32'(max_out <= 2), 32'(1));
        check_eq("f1_idle", 32'(busy), 32'(0));

        // Abort after 500 pixels with the sink stalled.
        start_frame();
        stream(500, 1, 1'b0, -1, 2000);
        out_ready = 1'b0;
        tick();
        tick();
        check_eq("pre_abort_valid", 32'(out_valid), 32'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_valid", 32'(out_valid), 32'(0));
        check_eq("abort_busy", 32'(busy), 32'(0));
        quiet_done = 0;
        for (int c = 0; c < 5; c++) begin
            quiet_done += int'(done) + int'(out_valid);
            tick();
        end
        check_eq("abort_quiet", 32'(quiet_done), 32'(0));

        // start and abort together while idle: nothing starts.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", 32'(busy), 32'(0));
        tick(); tick(); tick();
        check_eq("start_abort_valid", 32'({busy, out_valid}), 32'(0));

        // Fresh frame with random backpressure and a stray start mid-scan.
        start_frame();
        check_eq("f2_addr", 32'({read_y, read_x}), 32'(0));
        stream(N, 4, 1'b1, 50, 6000);
        check_eq("f2_count", 32'(idx), 32'(N));
        check_eq("f2_tags", 32'({sof_cnt[7:0], eol_cnt[7:0], eof_cnt[7:0]}),
                 32'({8'd1, 8'(H), 8'd1}));
        check_eq("f2_done_cnt", 32'(done_cnt), 32'(1));
        check_eq("f2_max_out", 32'(max_out <= 2), 32'(1));
        check_eq("f2_idle", 32'(busy), 32'(0));

        // Asynchronous reset in the middle of a frame.
        start_frame();
        stream(300, 1, 1'b0, -1, 1000);
        resetn = 1'b0;
        #1;
        check_eq("rst_addr", 32'({read_y, read_x}), 32'(0));
        check_eq("rst_data", 32'(out_data), 32'(0));
        check_eq("rst_flags", 32'({out_valid, out_sof, out_eol, out_eof, busy, done}), 32'(0));
        #3 resetn = 1'b1;
        quiet_done = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            quiet_done += int'(out_valid) + int'(busy);
        end
        check_eq("rst_quiet", 32'(quiet_done), 32'(0));

        // Single-column instance: every pixel ends a row.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        d1 = 0; i1 = 0;
        for (int c = 0; c < 10; c++) begin
            if (done1) d1++;
            if (out_valid1) begin
                check_eq($sformatf("w1_pix%0d", i1),
                         32'({out_sof1, out_eol1, out_eof1, out_data1}),
                         32'({i1 == 0, 1'b1, i1 == 1, exp_rgb(0, i1)}));
                i1++;
            end
            tick();
        end
        check_eq("w1_count", 32'(i1), 32'(2));
        check_eq("w1_done", 32'(d1), 32'(1));

`ifdef THUMB_STREAMER_GRAY_EN
        // Grayscale conversion of two constant pixels.
        gray_force = 1'b1;
        out_ready  = 1'b0;
        gray_word  = 32'h00FF8001;
        start_frame();
        for (int c = 0; c < 6 && !out_valid; c++) tick();
        check_eq("gray_mid_valid", 32'(out_valid), 32'(1));
        check_eq("gray_mid", 32'(out_data), 32'h00808080);
        abort = 1'b1; tick(); abort = 1'b0; tick();
        gray_word = 32'hFFFFFFFF;
        start_frame();
        for (int c = 0; c < 6 && !out_valid; c++) tick();
        check_eq("gray_full", 32'(out_data), 32'h00FFFFFF);
        abort = 1'b1; tick(); abort = 1'b0;
        gray_force = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
